// File: rtl/axis_host_driver.sv
// Host-side AXI-Stream driver: buffers one input frame, runs the 4-phase start
// handshake, streams the frame out, collects the result words and holds them for readback.
module axis_host_driver #(
  parameter int DATAWIDTH  = 32,
  parameter int INPDATANUM = 8,
  parameter int OUTDATANUM = 4,
  localparam int INPADRWIDTH = $clog2(INPDATANUM),
  localparam int OUTADRWIDTH = $clog2(OUTDATANUM)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_start,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  input  logic                   ld_wr,
  input  logic [INPADRWIDTH-1:0] ld_adr,
  input  logic [DATAWIDTH-1:0]   ld_data,
  input  logic [OUTADRWIDTH-1:0] rd_adr,
  output logic [DATAWIDTH-1:0]   rd_data,
  output logic                   ex_start,
  input  logic                   ex_startAck,
  output logic [DATAWIDTH-1:0]   m_data,
  output logic                   m_valid,
  output logic                   m_last,
  input  logic                   m_ready,
  input  logic [DATAWIDTH-1:0]   s_data,
  input  logic                   s_valid,
  input  logic                   s_last,
  output logic                   s_ready,
  output logic [2:0]             dbg_state
);

  // Stream handshake: a beat transfers on any rising edge where valid and ready
  // are both high; valid and the payload stay constant until that beat happens.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_REL  = 3'd2,
    S_SEND = 3'd3,
    S_RECV = 3'd4,
    S_DONE = 3'd5
  } state_t;

  localparam logic [INPADRWIDTH-1:0] ILAST = INPADRWIDTH'(INPDATANUM - 1);
  localparam logic [OUTADRWIDTH-1:0] OLAST = OUTADRWIDTH'(OUTDATANUM - 1);

  state_t                 r_state;
  logic [INPADRWIDTH-1:0] r_ict;
  logic [OUTADRWIDTH-1:0] r_oct;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_err;
  logic                   r_ex_start;
  logic                   r_m_valid;
  logic                   r_s_ready;
  logic [DATAWIDTH-1:0]   r_inbuf  [INPDATANUM];
  logic [DATAWIDTH-1:0]   r_outbuf [OUTDATANUM];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_ict      <= '0;
      r_oct      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_ex_start <= 1'b0;
      r_m_valid  <= 1'b0;
      r_s_ready  <= 1'b0;
      for (int i = 0; i < INPDATANUM; i++) r_inbuf[i] <= '0;
      for (int i = 0; i < OUTDATANUM; i++) r_outbuf[i] <= '0;
    end else begin
      // Loads are only taken while idle or done so the frame in flight never changes.
      if (ld_wr && !r_busy) r_inbuf[ld_adr] <= ld_data;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (cmd_start) begin
            r_state    <= S_REQ;
            r_err      <= 1'b0;
            r_ict      <= '0;
            r_oct      <= '0;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_ex_start <= 1'b1;
          end
        end
        S_REQ: begin
          if (ex_startAck) begin
            r_state    <= S_REL;
            r_ex_start <= 1'b0;
          end
        end
        S_REL: begin
          if (!ex_startAck) begin
            r_state   <= S_SEND;
            r_m_valid <= 1'b1;
          end
        end
        S_SEND: begin
          if (m_ready) begin
            if (r_ict == ILAST) begin
              r_state   <= S_RECV;
              r_m_valid <= 1'b0;
              r_s_ready <= 1'b1;
            end else begin
              r_ict <= r_ict + INPADRWIDTH'(1);
            end
          end
        end
        S_RECV: begin
          if (s_valid) begin
            r_outbuf[r_oct] <= s_data;
            // Framing is only flagged; completion is decided by the word count.
            if (s_last != (r_oct == OLAST)) r_err <= 1'b1;
            if (r_oct == OLAST) begin
              r_state   <= S_DONE;
              r_s_ready <= 1'b0;
              r_busy    <= 1'b0;
              r_done    <= 1'b1;
            end else begin
              r_oct <= r_oct + OUTADRWIDTH'(1);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign ex_start  = r_ex_start;
  assign m_valid   = r_m_valid;
  assign s_ready   = r_s_ready;
  assign m_data    = r_m_valid ? r_inbuf[r_ict] : '0;
  assign m_last    = r_m_valid && (r_ict == ILAST);
  assign rd_data   = r_outbuf[rd_adr];
  assign dbg_state = r_state;

endmodule

// File: tb/tb_axis_host_driver.sv
// Bench for axis_host_driver: directed transactions against a simple accelerator
// peer, with a scoreboard monitor checking every master beat against the loaded frame.
module tb_axis_host_driver;

  localparam int DW  = 32;
  localparam int IN  = 8;
  localparam int ON  = 4;
  localparam int IAW = 3;
  localparam int OAW = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           cmd_start;
  logic           busy, done, err;
  logic           ld_wr;
  logic [IAW-1:0] ld_adr;
  logic [DW-1:0]  ld_data;
  logic [OAW-1:0] rd_adr;
  logic [DW-1:0]  rd_data;
  logic           ex_start, ex_startAck;
  logic [DW-1:0]  m_data;
  logic           m_valid, m_last, m_ready;
  logic [DW-1:0]  s_data;
  logic           s_valid, s_last, s_ready;
  logic [2:0]     dbg_state;

  axis_host_driver #(.DATAWIDTH(DW), .INPDATANUM(IN), .OUTDATANUM(ON)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_start(cmd_start), .busy(busy), .done(done), .err(err),
    .ld_wr(ld_wr), .ld_adr(ld_adr), .ld_data(ld_data), .rd_adr(rd_adr), .rd_data(rd_data),
    .ex_start(ex_start), .ex_startAck(ex_startAck),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          errors = 0;
  logic [32:0] exp_q[$];
  logic [31:0] model_in [IN];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: pops one expected {last,data} per master beat, and checks the
  // payload held during a stall matches what was presented before it.
  logic        stalled_prev = 1'b0;
  logic [32:0] held;
  always @(negedge clk) begin
    if (!rst_n) begin
      stalled_prev = 1'b0;
    end else begin
      if (stalled_prev && m_valid) check("m_stable", {31'd0, m_last}, {31'd0, held[32]});
      if (stalled_prev && m_valid) check("m_stable_data", m_data, held[31:0]);
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check("m_unexpected_beat", {31'd0, m_valid}, 32'd0);
        end else begin
          logic [32:0] e;
          e = exp_q.pop_front();
          check("m_data", m_data, e[31:0]);
          check("m_last", {31'd0, m_last}, {31'd0, e[32]});
        end
      end
      stalled_prev = m_valid && !m_ready;
      held = {m_last, m_data};
    end
  end

  int   ex_rises = 0, busy_falls = 0;
  logic prev_ex = 1'b0, prev_busy = 1'b0;
  always @(negedge clk) begin
    if (ex_start && !prev_ex) ex_rises++;
    if (!busy && prev_busy) busy_falls++;
    prev_ex   = ex_start;
    prev_busy = busy;
  end

  // ---------------- driver tasks ----------------
  task automatic load(input int adr, input logic [31:0] data);
    ld_wr = 1'b1; ld_adr = IAW'(adr); ld_data = data;
    @(posedge clk); #1;
    ld_wr = 1'b0;
  endtask

  task automatic check_rd(input string tag, input logic [127:0] exp);
    for (int i = 0; i < ON; i++) begin
      rd_adr = OAW'(i);
      #1;
      check(tag, rd_data, exp[i*32 +: 32]);
    end
  endtask

  task automatic run_txn(input int ack_dly, input logic [3:0] rdy_pat, input logic [127:0] res,
                         input logic [3:0] lasts, input int abort_beats, input bit busy_wr,
                         input bit hold);
    int beats, vcyc, t, rwait;
    bit wrote;
    for (int i = 0; i < IN; i++) exp_q.push_back({(i == IN - 1), model_in[i]});
    cmd_start = 1'b1;
    @(posedge clk); #1;
    if (!hold) cmd_start = 1'b0;
    @(negedge clk);
    check("ex_start_rise", {31'd0, ex_start}, 32'd1);
    check("busy_in_req", {31'd0, busy}, 32'd1);
    check("err_cleared", {31'd0, err}, 32'd0);
    check("done_dropped", {31'd0, done}, 32'd0);
    for (int d = 0; d < ack_dly; d++) begin @(posedge clk); #1; end
    ex_startAck = 1'b1;
    for (t = 0; t < 20; t++) begin
      @(negedge clk);
      if (!ex_start) break;
    end
    check("ex_start_drop", {31'd0, ex_start}, 32'd0);
    @(posedge clk); #1;
    ex_startAck = 1'b0;
    beats = 0; vcyc = 0; wrote = 1'b0;
    for (int cyc = 0; cyc < 200 && beats < IN; cyc++) begin
      m_ready = rdy_pat[cyc % 4];
      @(negedge clk);
      if (m_valid) vcyc++;
      if (m_valid && m_ready) beats++;
      @(posedge clk); #1;
      ld_wr = 1'b0;
      if (busy_wr && beats == 2 && !wrote) begin
        ld_wr = 1'b1; ld_adr = '0; ld_data = 32'hFFFF; wrote = 1'b1;
      end
      if (abort_beats != 0 && beats == abort_beats) begin
        rst_n = 1'b0; m_ready = 1'b0; cmd_start = 1'b0;
        #1;
        check("rst_m_valid", {31'd0, m_valid}, 32'd0);
        check("rst_ex_start", {31'd0, ex_start}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_state", {29'd0, dbg_state}, 32'd0);
        check_rd("rst_rd_data", 128'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_q.delete();
        for (int i = 0; i < IN; i++) model_in[i] = '0;
        return;
      end
    end
    ld_wr = 1'b0; m_ready = 1'b0;
    check("send_beats", beats, IN);
    if (rdy_pat == 4'hF) check("send_cycles", vcyc, IN);
    rwait = 0;
    for (int i = 0; i < ON; i++) begin
      s_valid = 1'b1; s_data = res[i*32 +: 32]; s_last = lasts[i];
      for (t = 0; t < 20; t++) begin
        @(negedge clk);
        if (s_ready) break;
        @(posedge clk); #1;
      end
      rwait += t;
      check("recv_ready", {31'd0, s_ready}, 32'd1);
      @(posedge clk); #1;
    end
    s_valid = 1'b0; s_last = 1'b0;
    if (hold) cmd_start = 1'b0;
    check("recv_wait", rwait, 0);
    @(negedge clk);
    check("done_set", {31'd0, done}, 32'd1);
    check("busy_clear", {31'd0, busy}, 32'd0);
    check("s_ready_clear", {31'd0, s_ready}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int e0, b0;
    rst_n = 1'b0; cmd_start = 1'b0; ld_wr = 1'b0; ld_adr = '0; ld_data = '0; rd_adr = '0;
    ex_startAck = 1'b0; m_ready = 1'b0; s_data = '0; s_valid = 1'b0; s_last = 1'b0;
    for (int i = 0; i < IN; i++) model_in[i] = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_err", {31'd0, err}, 32'd0);
    check("reset_ex_start", {31'd0, ex_start}, 32'd0);
    check("reset_m_valid", {31'd0, m_valid}, 32'd0);
    check("reset_s_ready", {31'd0, s_ready}, 32'd0);
    check("reset_m_data", m_data, 32'd0);
    check_rd("reset_rd_data", 128'd0);
    @(posedge clk); #1;

    // Basic frame 0x10..0x17, results 0xA0..0xA3
    for (int i = 0; i < IN; i++) begin load(i, 32'h10 + i); model_in[i] = 32'h10 + i; end
    run_txn(2, 4'hF, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 4'b1000, 0, 1'b0, 1'b0);
    check("basic_err", {31'd0, err}, 32'd0);
    check_rd("basic_rd", {32'hA3, 32'hA2, 32'hA1, 32'hA0});
    @(posedge clk); #1;

    // Reset after 3 sent beats
    run_txn(1, 4'hF, 128'd0, 4'b1000, 3, 1'b0, 1'b0);
    @(negedge clk);
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    check("post_rst_m_valid", {31'd0, m_valid}, 32'd0);
    @(posedge clk); #1;

    // Backpressure pattern 1,0,0,1
    for (int i = 0; i < IN; i++) begin load(i, 32'h20 + i); model_in[i] = 32'h20 + i; end
    run_txn(1, 4'b1001, {32'hB3, 32'hB2, 32'hB1, 32'hB0}, 4'b1000, 0, 1'b0, 1'b0);
    check("stall_err", {31'd0, err}, 32'd0);
    check_rd("stall_rd", {32'hB3, 32'hB2, 32'hB1, 32'hB0});
    @(posedge clk); #1;

    // Early s_last on 2nd result beat, plus a load attempt during SEND
    run_txn(0, 4'hF, {32'hC3, 32'hC2, 32'hC1, 32'hC0}, 4'b1010, 0, 1'b1, 1'b0);
    check("frame_err", {31'd0, err}, 32'd1);
    check_rd("frame_rd", {32'hC3, 32'hC2, 32'hC1, 32'hC0});
    @(posedge clk); #1;

    // Next transaction clears err; word 0 must still be 0x20
    run_txn(1, 4'hF, {32'hD3, 32'hD2, 32'hD1, 32'hD0}, 4'b1000, 0, 1'b0, 1'b0);
    check("clear_err", {31'd0, err}, 32'd0);
    check_rd("clear_rd", {32'hD3, 32'hD2, 32'hD1, 32'hD0});
    @(posedge clk); #1;

    // Preload in DONE, then a run with cmd_start held high throughout
    load(0, 32'hFFFF); model_in[0] = 32'hFFFF;
    e0 = ex_rises; b0 = busy_falls;
    run_txn(1, 4'hF, {32'hE3, 32'hE2, 32'hE1, 32'hE0}, 4'b1000, 0, 1'b0, 1'b1);
    @(posedge clk); #1;
    check("hold_ex_pulses", ex_rises - e0, 1);
    check("hold_busy_falls", busy_falls - b0, 1);
    check("hold_stays_done", {31'd0, done}, 32'd1);
    check_rd("hold_rd", {32'hE3, 32'hE2, 32'hE1, 32'hE0});

    check("exp_q_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
